// File: rtl/spi_req_arbiter_pkg.sv
// Shared types and helpers for the SPI flash request arbiter.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } arb_state_t;

  // ARB_IDX_W: index width for n requesters, never narrower than one bit
  function automatic int arb_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_req_arbiter_if.sv
// Requester-side and flash-controller-side signals of the arbiter.
// slave: the arbiter's view; master: the view of whatever drives it.
interface spi_req_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [NUM_REQ-1:0]            i_req_valid;
  logic [NUM_REQ-1:0]            i_req_rd0_wr1;
  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_wdata;
  logic [NUM_REQ-1:0]            o_req_ready;
  logic [NUM_REQ-1:0]            o_req_rd_valid;
  logic [DATA_WIDTH-1:0]         o_req_rd_data;
  logic                          o_valid;
  logic                          o_rd0_wr1;
  logic [ADDR_WIDTH-1:0]         o_addr;
  logic [DATA_WIDTH-1:0]         o_wr_data;
  logic                          i_ready;
  logic                          i_rd_valid;
  logic [DATA_WIDTH-1:0]         i_rd_data;
  logic                          o_unexp_rd;

  modport slave (
    input  i_req_valid, i_req_rd0_wr1, i_req_addr, i_req_wdata,
    input  i_ready, i_rd_valid, i_rd_data,
    output o_req_ready, o_req_rd_valid, o_req_rd_data,
    output o_valid, o_rd0_wr1, o_addr, o_wr_data, o_unexp_rd
  );

  modport master (
    output i_req_valid, i_req_rd0_wr1, i_req_addr, i_req_wdata,
    output i_ready, i_rd_valid, i_rd_data,
    input  o_req_ready, o_req_rd_valid, o_req_rd_data,
    input  o_valid, o_rd0_wr1, o_addr, o_wr_data, o_unexp_rd
  );
endinterface

// File: rtl/spi_req_arbiter_rr_picker.sv
// Combinational winner selection: first requester at or after i_ptr.
// Macro ARB_FIXED_PRIO_EN switches to strict priority (lowest index wins, i_ptr ignored).
module rr_picker
  import spi_arb_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int IW      = arb_idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IW-1:0]      o_idx,
  output logic               o_any
);

  // pick one requester and report it both one-hot and as an index
  always_comb begin
    int w_j;
    w_j     = 0;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req[k]) begin
        o_grant    = '0;
        o_grant[k] = 1'b1;
        o_idx      = IW'(k);
        o_any      = 1'b1;
      end
    end
`else
    for (int k = 0; k < NUM_REQ; k++) begin
      w_j = (int'(i_ptr) + k) % NUM_REQ;
      if (!o_any && i_req[w_j]) begin
        o_grant[w_j] = 1'b1;
        o_idx        = IW'(w_j);
        o_any        = 1'b1;
      end
    end
`endif
  end

endmodule

// File: rtl/spi_req_arbiter.sv
// Shares one flash-controller request port among NUM_REQ requesters.
// One transaction in flight at a time; a read is tracked until its data returns
// and the data is routed to the owner. Macro ARB_FIXED_PRIO_EN selects strict priority.
module spi_req_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input logic              i_clk_ahb,
  input logic              i_rstn_ahb,
  spi_req_arbiter_if.slave bus
);

  localparam int IW = arb_idx_w(NUM_REQ);

  arb_state_t            r_state, w_state_nxt;
  logic [IW-1:0]         r_owner, w_rr_ptr, w_win_idx;
  logic [NUM_REQ-1:0]    w_grant, r_req_rd_valid;
  logic                  w_any, w_accept, w_wr_done, w_rd_done, w_unexp;
  logic                  r_valid, r_rd0_wr1, r_unexp_rd;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata, r_rd_data;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .i_req   (bus.i_req_valid),
    .i_ptr   (w_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_win_idx),
    .o_any   (w_any)
  );

  // state register
  always_ff @(posedge i_clk_ahb) begin
    if (!i_rstn_ahb) r_state <= IDLE;
    else             r_state <= w_state_nxt;
  end

  // next state and transaction events; stray read data is flagged, never consumed
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_wr_done   = 1'b0;
    w_rd_done   = 1'b0;
    w_unexp     = 1'b0;
    case (r_state)
      IDLE: begin
        w_unexp = bus.i_rd_valid;
        if (w_any) begin
          w_accept    = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.i_ready) begin
          if (r_rd0_wr1) begin
            w_wr_done   = 1'b1;
            w_unexp     = bus.i_rd_valid;
            w_state_nxt = IDLE;
          end else if (bus.i_rd_valid) begin
            w_rd_done   = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = WAIT_RD;
          end
        end else begin
          // read not yet accepted downstream, so nothing can be owed to us
          w_unexp = bus.i_rd_valid;
        end
      end
      WAIT_RD: begin
        if (bus.i_rd_valid) begin
          w_rd_done   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // payload capture, downstream valid, read return and stray-data pulse
  always_ff @(posedge i_clk_ahb) begin
    if (!i_rstn_ahb) begin
      r_valid        <= 1'b0;
      r_owner        <= '0;
      r_rd0_wr1      <= 1'b0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_req_rd_valid <= '0;
      r_rd_data      <= '0;
      r_unexp_rd     <= 1'b0;
    end else begin
      r_req_rd_valid <= '0;
      r_unexp_rd     <= w_unexp;
      if (w_accept) begin
        r_valid   <= 1'b1;
        r_owner   <= w_win_idx;
        r_rd0_wr1 <= bus.i_req_rd0_wr1[w_win_idx];
        r_addr    <= bus.i_req_addr[w_win_idx*ADDR_WIDTH +: ADDR_WIDTH];
        r_wdata   <= bus.i_req_wdata[w_win_idx*DATA_WIDTH +: DATA_WIDTH];
      end else if (r_state == ISSUE && bus.i_ready) begin
        r_valid <= 1'b0;
      end
      if (w_rd_done) begin
        r_req_rd_valid[r_owner] <= 1'b1;
        r_rd_data               <= bus.i_rd_data;
      end
    end
  end

`ifdef ARB_FIXED_PRIO_EN
  assign w_rr_ptr = '0;
`else
  logic [IW-1:0] r_rr_ptr;

  // fairness pointer moves past the owner only once its transaction has finished
  always_ff @(posedge i_clk_ahb) begin
    if (!i_rstn_ahb)                r_rr_ptr <= '0;
    else if (w_wr_done || w_rd_done) r_rr_ptr <= IW'((int'(r_owner) + 1) % NUM_REQ);
  end

  assign w_rr_ptr = r_rr_ptr;
`endif

  assign bus.o_req_ready    = (r_state == IDLE) ? w_grant : '0;
  assign bus.o_req_rd_valid = r_req_rd_valid;
  assign bus.o_req_rd_data  = r_rd_data;
  assign bus.o_valid        = r_valid;
  assign bus.o_rd0_wr1      = r_rd0_wr1;
  assign bus.o_addr         = r_addr;
  assign bus.o_wr_data      = r_wdata;
  assign bus.o_unexp_rd     = r_unexp_rd;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed bench for spi_req_arbiter (default round-robin build, two requesters).
module tb_spi_req_arbiter;

  logic clk;
  logic rstn;
  int   total;
  int   bad;

  logic [31:0] a0, a1, d0, d1;

  spi_req_arbiter_if #(.NUM_REQ(2), .DATA_WIDTH(32), .ADDR_WIDTH(32)) bus_if ();

  spi_req_arbiter #(.NUM_REQ(2), .DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .i_clk_ahb  (clk),
    .i_rstn_ahb (rstn),
    .bus        (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    bus_if.i_req_addr  = {a1, a0};
    bus_if.i_req_wdata = {d1, d0};
  end

  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  wr;
    logic        ready;
    logic        rdv;
    logic [31:0] rdata;
    logic [1:0]  e_rdy;
    logic        e_valid;
    logic        e_wr;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [1:0]  e_rdv;
    logic [31:0] e_rdata;
    logic        e_unexp;
  } vec_t;

  vec_t tbl[32];
  int   n_vec;

  task automatic add(input logic [1:0] valid, input logic [1:0] wr, input logic ready,
                     input logic rdv, input logic [31:0] rdata, input logic [1:0] e_rdy,
                     input logic e_valid, input logic e_wr, input logic [31:0] e_addr,
                     input logic [31:0] e_wdata, input logic [1:0] e_rdv,
                     input logic [31:0] e_rdata, input logic e_unexp);
    tbl[n_vec] = '{valid, wr, ready, rdv, rdata, e_rdy, e_valid, e_wr, e_addr, e_wdata,
                   e_rdv, e_rdata, e_unexp};
    n_vec++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] valid, input logic [1:0] wr, input logic ready,
                       input logic rdv, input logic [31:0] rdata);
    bus_if.i_req_valid   = valid;
    bus_if.i_req_rd0_wr1 = wr;
    bus_if.i_ready       = ready;
    bus_if.i_rd_valid    = rdv;
    bus_if.i_rd_data     = rdata;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " o_valid"},        32'(bus_if.o_valid),        32'h0);
    chk({tag, " o_rd0_wr1"},      32'(bus_if.o_rd0_wr1),      32'h0);
    chk({tag, " o_addr"},         bus_if.o_addr,              32'h0);
    chk({tag, " o_wr_data"},      bus_if.o_wr_data,           32'h0);
    chk({tag, " o_req_ready"},    32'(bus_if.o_req_ready),    32'h0);
    chk({tag, " o_req_rd_valid"}, 32'(bus_if.o_req_rd_valid), 32'h0);
    chk({tag, " o_req_rd_data"},  bus_if.o_req_rd_data,       32'h0);
    chk({tag, " o_unexp_rd"},     32'(bus_if.o_unexp_rd),     32'h0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    n_vec = 0;
    a0 = 32'h10; d0 = 32'hCAFE;
    a1 = 32'h20; d1 = 32'hBEEF;

    // write by req0, ready tied high
    add(2'b01, 2'b01, 1, 0, 32'h0,  2'b01, 0, 0, 32'h0,  32'h0,    2'b00, 32'h0,  0);
    add(2'b00, 2'b00, 1, 0, 32'h0,  2'b00, 1, 1, 32'h10, 32'hCAFE, 2'b00, 32'h0,  0);
    // both reading continuously: grants alternate, data routed to its owner
    add(2'b11, 2'b00, 1, 0, 32'h0,  2'b10, 0, 0, 32'h0,  32'h0,    2'b00, 32'h0,  0);
    add(2'b11, 2'b00, 1, 0, 32'h0,  2'b00, 1, 0, 32'h20, 32'hBEEF, 2'b00, 32'h0,  0);
    add(2'b11, 2'b00, 1, 1, 32'h22, 2'b00, 0, 0, 32'h0,  32'h0,    2'b00, 32'h0,  0);
    add(2'b11, 2'b00, 1, 0, 32'h0,  2'b01, 0, 0, 32'h0,  32'h0,    2'b10, 32'h22, 0);
    add(2'b11, 2'b00, 1, 0, 32'h0,  2'b00, 1, 0, 32'h10, 32'hCAFE, 2'b00, 32'h22, 0);
    add(2'b11, 2'b00, 1, 1, 32'h11, 2'b00, 0, 0, 32'h0,  32'h0,    2'b00, 32'h22, 0);
    add(2'b11, 2'b00, 1, 0, 32'h0,  2'b10, 0, 0, 32'h0,  32'h0,    2'b01, 32'h11, 0);
    add(2'b11, 2'b00, 1, 0, 32'h0,  2'b00, 1, 0, 32'h20, 32'hBEEF, 2'b00, 32'h11, 0);
    add(2'b11, 2'b00, 1, 1, 32'h22, 2'b00, 0, 0, 32'h0,  32'h0,    2'b00, 32'h11, 0);
    add(2'b00, 2'b00, 1, 0, 32'h0,  2'b00, 0, 0, 32'h0,  32'h0,    2'b10, 32'h22, 0);
    // read with ready and rd_valid in the same cycle
    add(2'b10, 2'b00, 1, 0, 32'h0,  2'b10, 0, 0, 32'h0,  32'h0,    2'b00, 32'h22, 0);
    add(2'b00, 2'b00, 1, 1, 32'h5A, 2'b00, 1, 0, 32'h20, 32'hBEEF, 2'b00, 32'h22, 0);
    add(2'b00, 2'b00, 0, 0, 32'h0,  2'b00, 0, 0, 32'h0,  32'h0,    2'b10, 32'h5A, 0);
    // stray read data while idle
    add(2'b00, 2'b00, 0, 1, 32'h77, 2'b00, 0, 0, 32'h0,  32'h0,    2'b00, 32'h5A, 0);
    add(2'b00, 2'b00, 0, 0, 32'h0,  2'b00, 0, 0, 32'h0,  32'h0,    2'b00, 32'h5A, 1);
    add(2'b00, 2'b00, 0, 0, 32'h0,  2'b00, 0, 0, 32'h0,  32'h0,    2'b00, 32'h5A, 0);

    rstn = 1'b0;
    drive(2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk_all_zero("reset");
    rstn = 1'b1;

    for (int k = 0; k < n_vec; k++) begin
      drive(tbl[k].valid, tbl[k].wr, tbl[k].ready, tbl[k].rdv, tbl[k].rdata);
      #1;
      chk($sformatf("v%0d o_req_ready", k),    32'(bus_if.o_req_ready),    32'(tbl[k].e_rdy));
      chk($sformatf("v%0d o_valid", k),        32'(bus_if.o_valid),        32'(tbl[k].e_valid));
      chk($sformatf("v%0d o_req_rd_valid", k), 32'(bus_if.o_req_rd_valid), 32'(tbl[k].e_rdv));
      chk($sformatf("v%0d o_req_rd_data", k),  bus_if.o_req_rd_data,       tbl[k].e_rdata);
      chk($sformatf("v%0d o_unexp_rd", k),     32'(bus_if.o_unexp_rd),     32'(tbl[k].e_unexp));
      if (tbl[k].e_valid) begin
        chk($sformatf("v%0d o_rd0_wr1", k), 32'(bus_if.o_rd0_wr1), 32'(tbl[k].e_wr));
        chk($sformatf("v%0d o_addr", k),    bus_if.o_addr,         tbl[k].e_addr);
        chk($sformatf("v%0d o_wr_data", k), bus_if.o_wr_data,      tbl[k].e_wdata);
      end
      @(negedge clk);
    end

    // write stalled by i_ready low for 5 cycles; req1 waiting must not be granted
    a0 = 32'h44; d0 = 32'hDEAD;
    drive(2'b01, 2'b01, 1'b0, 1'b0, 32'h0);
    #1;
    chk("stall grant0", 32'(bus_if.o_req_ready), 32'h1);
    @(negedge clk);
    drive(2'b11, 2'b11, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("stall%0d o_valid", i),     32'(bus_if.o_valid),     32'h1);
      chk($sformatf("stall%0d o_rd0_wr1", i),   32'(bus_if.o_rd0_wr1),   32'h1);
      chk($sformatf("stall%0d o_addr", i),      bus_if.o_addr,           32'h44);
      chk($sformatf("stall%0d o_wr_data", i),   bus_if.o_wr_data,        32'hDEAD);
      chk($sformatf("stall%0d o_req_ready", i), 32'(bus_if.o_req_ready), 32'h0);
      @(negedge clk);
    end
    bus_if.i_ready = 1'b1;
    #1;
    chk("stall release o_valid", 32'(bus_if.o_valid), 32'h1);
    @(negedge clk);
    #1;
    chk("after stall o_valid", 32'(bus_if.o_valid), 32'h0);
    chk("after stall rr grant1", 32'(bus_if.o_req_ready), 32'h2);
    drive(2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
    @(negedge clk);

    // reset while a read is outstanding; late data is then unexpected
    drive(2'b01, 2'b00, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    drive(2'b00, 2'b00, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    #1;
    chk("wait_rd o_valid", 32'(bus_if.o_valid), 32'h0);
    rstn = 1'b0;
    @(negedge clk);
    #1;
    chk_all_zero("mid reset");
    rstn = 1'b1;
    drive(2'b00, 2'b00, 1'b0, 1'b1, 32'h99);
    @(negedge clk);
    drive(2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
    #1;
    chk("late rd o_unexp_rd",     32'(bus_if.o_unexp_rd),     32'h1);
    chk("late rd o_req_rd_valid", 32'(bus_if.o_req_rd_valid), 32'h0);
    chk("late rd o_req_rd_data",  bus_if.o_req_rd_data,       32'h0);
    @(negedge clk);
    #1;
    chk("late rd pulse end", 32'(bus_if.o_unexp_rd), 32'h0);
    bus_if.i_req_valid = 2'b11;
    #1;
    chk("post reset rr grant0", 32'(bus_if.o_req_ready), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
